instr_fetch_queue: RTL and testbench

INSTR_FETCH_QUEUE -- requirements
Module: instr_fetch_queue

---
 rtl/instr_fetch_queue.sv | 96 +++++++++
 tb/tb_instr_fetch_queue.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: 16-entry program memory feeding a DEPTH-entry (2 or 4) FIFO.
// Define FETCH_PARITY_EN to store per-entry even parity and add the instr_parity_err output.
module instr_fetch_queue #(
   parameter int INSTR_W = 8,
   parameter int DEPTH   = 2
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [3:0]         pc,
   input  logic               pc_valid,
   output logic               pc_ready,
   input  logic               prog_we,
   input  logic [3:0]         prog_addr,
   input  logic [INSTR_W-1:0] prog_data,
   input  logic               flush,
   output logic [INSTR_W-1:0] instr,
   output logic [3:0]         instr_pc,
`ifdef FETCH_PARITY_EN
   output logic               instr_parity_err,
`endif
   output logic               instr_valid,
   input  logic               instr_ready
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

   logic [INSTR_W-1:0] mem [16];
   logic [INSTR_W-1:0] q_instr [DEPTH];
   logic [3:0]         q_pc [DEPTH];
   logic [PTR_W-1:0]   rd_ptr_reg;
   logic [PTR_W-1:0]   wr_ptr_reg;
   logic [CNT_W-1:0]   count_reg;
   logic               push;
   logic               pop;
   logic [INSTR_W-1:0] fetch_word;

   // Read before the write lands, so a same-cycle write to pc is seen as old data.
   assign fetch_word  = mem[pc];
   assign pc_ready    = (count_reg < FULL);
   assign instr_valid = (count_reg != '0);
   assign push        = pc_valid && pc_ready;
   assign pop         = instr_valid && instr_ready;

   always_ff @(posedge clk) begin
      if (prog_we) begin
         mem[prog_addr] <= prog_data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else if (flush) begin
         rd_ptr_reg <= '0;
         wr_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         if (push && !pop) begin
            count_reg <= count_reg + 1'b1;
         end else if (pop && !push) begin
            count_reg <= count_reg - 1'b1;
         end
      end
   end

`ifdef FETCH_PARITY_EN
   logic q_par [DEPTH];
`endif

   // Entry storage carries no reset; the occupancy count alone decides validity.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         q_instr[wr_ptr_reg] <= fetch_word;
         q_pc[wr_ptr_reg]    <= pc;
`ifdef FETCH_PARITY_EN
         q_par[wr_ptr_reg]   <= ^fetch_word;
`endif
      end
   end

   assign instr    = instr_valid ? q_instr[rd_ptr_reg] : '0;
   assign instr_pc = instr_valid ? q_pc[rd_ptr_reg]    : '0;

`ifdef FETCH_PARITY_EN
   assign instr_parity_err = instr_valid && (q_par[rd_ptr_reg] != ^instr);
`endif
endmodule

// File: tb/tb_instr_fetch_queue.sv
// Scoreboard bench for instr_fetch_queue: a reference queue of {pc, instr} tracks every
// accepted fetch and is compared against the DUT head each cycle.
module tb_instr_fetch_queue;
   localparam int INSTR_W = 8;
   localparam int DEPTH   = 2;

   logic               clk = 1'b0;
   logic               reset = 1'b1;
   logic [3:0]         pc = '0;
   logic               pc_valid = 1'b0;
   logic               pc_ready;
   logic               prog_we = 1'b0;
   logic [3:0]         prog_addr = '0;
   logic [INSTR_W-1:0] prog_data = '0;
   logic               flush = 1'b0;
   logic [INSTR_W-1:0] instr;
   logic [3:0]         instr_pc;
   logic               instr_valid;
   logic               instr_ready = 1'b0;
`ifdef FETCH_PARITY_EN
   logic               instr_parity_err;
`endif

   typedef struct packed {
      logic       v;
      logic [3:0] pc;
      logic       rdy;
      logic       fl;
      logic       we;
      logic [3:0] wa;
      logic [7:0] wd;
   } stim_t;

   logic [11:0]        sb [$];
   logic [INSTR_W-1:0] mem_m [16];
   int                 n_checks = 0;
   int                 n_fail = 0;

   instr_fetch_queue #(.INSTR_W(INSTR_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset), .pc(pc), .pc_valid(pc_valid), .pc_ready(pc_ready),
      .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data), .flush(flush),
      .instr(instr), .instr_pc(instr_pc),
`ifdef FETCH_PARITY_EN
      .instr_parity_err(instr_parity_err),
`endif
      .instr_valid(instr_valid), .instr_ready(instr_ready)
   );

   always #5 clk = ~clk;

   function automatic stim_t st(logic v, logic [3:0] p, logic rdy, logic fl,
                                logic we, logic [3:0] wa, logic [7:0] wd);
      stim_t s;
      s.v = v; s.pc = p; s.rdy = rdy; s.fl = fl; s.we = we; s.wa = wa; s.wd = wd;
      return s;
   endfunction

   task automatic drive(input stim_t s);
      pc_valid = s.v; pc = s.pc; instr_ready = s.rdy; flush = s.fl;
      prog_we = s.we; prog_addr = s.wa; prog_data = s.wd;
   endtask

   // Advance the reference model by one edge using the currently driven inputs.
   task automatic commit_cycle();
      bit m_valid = (sb.size() > 0);
      bit m_ready = (sb.size() < DEPTH);
      if (flush) begin
         sb.delete();
      end else begin
         if (m_valid && instr_ready) void'(sb.pop_front());
         if (pc_valid && m_ready) sb.push_back({pc, mem_m[pc]});
      end
      if (prog_we) mem_m[prog_addr] = prog_data;
      @(posedge clk);
      #1;
   endtask

   task automatic write_mem(input logic [3:0] a, input logic [7:0] d);
      drive(st(1'b0, 4'd0, 1'b0, 1'b0, 1'b1, a, d));
      commit_cycle();
      prog_we = 1'b0;
   endtask

   task automatic test_reset();
      #2 reset = 1'b0;
      #2;
      n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", instr_valid); end
      n_checks++; if (pc_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", pc_ready); end
      n_checks++; if (instr !== 8'h00) begin n_fail++; $display("FAIL reset_instr: got %h want 00", instr); end
      n_checks++; if (instr_pc !== 4'h0) begin n_fail++; $display("FAIL reset_instr_pc: got %h want 0", instr_pc); end
      @(posedge clk); #1;
      for (int i = 0; i < 4; i++) write_mem(4'(i), 8'h10 + 8'(i));
      write_mem(4'd4, 8'h44);
      write_mem(4'd5, 8'hA0);
      write_mem(4'd6, 8'hA1);
      reset = 1'b1;
      $display("test_reset: done, memory loaded");
   endtask

   task automatic run_rows(input string tag, input stim_t rows [$]);
      foreach (rows[i]) begin
         drive(rows[i]);
         #1;
         n_checks++;
         if (instr_valid !== 1'((sb.size() > 0))) begin
            n_fail++; $display("FAIL %s_valid cyc%0d: got %b want %b", tag, i, instr_valid, sb.size() > 0);
         end
         n_checks++;
         if (pc_ready !== 1'((sb.size() < DEPTH))) begin
            n_fail++; $display("FAIL %s_ready cyc%0d: got %b want %b", tag, i, pc_ready, sb.size() < DEPTH);
         end
         if (sb.size() > 0) begin
            n_checks++;
            if ({instr_pc, instr} !== sb[0]) begin
               n_fail++; $display("FAIL %s_head cyc%0d: got pc=%h instr=%h want pc=%h instr=%h",
                                  tag, i, instr_pc, instr, sb[0][11:8], sb[0][7:0]);
            end else begin
               $display("%s cyc%0d: head pc=%h instr=%h rdy=%b", tag, i, instr_pc, instr, instr_ready);
            end
`ifdef FETCH_PARITY_EN
            n_checks++;
            if (instr_parity_err !== 1'b0) begin
               n_fail++; $display("FAIL %s_parity cyc%0d: got %b want 0", tag, i, instr_parity_err);
            end
`endif
         end
         commit_cycle();
      end
      drive(st(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0));
   endtask

   task automatic test_stream();
      stim_t r [$];
      for (int i = 0; i < 4; i++) r.push_back(st(1'b1, 4'(i), 1'b1, 1'b0, 1'b0, 4'd0, 8'd0));
      r.push_back(st(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0));
      r.push_back(st(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0));
      run_rows("stream", r);
   endtask

   task automatic test_backpressure();
      stim_t r [$];
      r.push_back(st(1'b1, 4'd5, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0));
      r.push_back(st(1'b1, 4'd6, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0));
      r.push_back(st(1'b1, 4'd7, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0));
      r.push_back(st(1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0));
      for (int i = 0; i < 3; i++) r.push_back(st(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0));
      run_rows("backpressure", r);
   endtask

   task automatic test_back_to_back();
      stim_t r [$];
      r.push_back(st(1'b1, 4'd2, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0));
      r.push_back(st(1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0));
      r.push_back(st(1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0));
      r.push_back(st(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0));
      r.push_back(st(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0));
      run_rows("back_to_back", r);
   endtask

   task automatic test_flush();
      stim_t r [$];
      r.push_back(st(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0));
      r.push_back(st(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0));
      r.push_back(st(1'b1, 4'd2, 1'b1, 1'b1, 1'b0, 4'd0, 8'd0));
      r.push_back(st(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0));
      r.push_back(st(1'b1, 4'd3, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0));
      r.push_back(st(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0));
      r.push_back(st(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0));
      run_rows("flush", r);
   endtask

   task automatic test_write_collision();
      stim_t r [$];
      r.push_back(st(1'b1, 4'd4, 1'b1, 1'b0, 1'b1, 4'd4, 8'hFF));
      r.push_back(st(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0));
      r.push_back(st(1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0));
      r.push_back(st(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0));
      r.push_back(st(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0));
      run_rows("collision", r);
   endtask

   task automatic test_reset_mid();
      stim_t r [$];
      r.push_back(st(1'b1, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0));
      r.push_back(st(1'b1, 4'd1, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0));
      run_rows("mid_fill", r);
      #2 reset = 1'b0;
      #1;
      n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_valid: got %b want 0", instr_valid); end
      n_checks++; if (pc_ready !== 1'b1) begin n_fail++; $display("FAIL midreset_ready: got %b want 1", pc_ready); end
      n_checks++; if (instr !== 8'h00) begin n_fail++; $display("FAIL midreset_instr: got %h want 00", instr); end
      sb.delete();
      $display("test_reset_mid: reset asserted with two entries queued");
      @(posedge clk); #1;
      reset = 1'b1;
      r.delete();
      r.push_back(st(1'b1, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0));
      r.push_back(st(1'b1, 4'd1, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0));
      r.push_back(st(1'b1, 4'd4, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0));
      r.push_back(st(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0));
      r.push_back(st(1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0));
      run_rows("post_reset", r);
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_back_to_back();
      test_flush();
      test_write_collision();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end
endmodule
